// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller: line states, bus commands,
// controller FSM states and the tag-width helper.
package msi_pkg;

  typedef logic [1:0] line_state_t;
  typedef logic [1:0] bus_cmd_t;

  localparam line_state_t LINE_I = 2'd0;
  localparam line_state_t LINE_S = 2'd1;
  localparam line_state_t LINE_M = 2'd2;

  localparam bus_cmd_t CMD_BUSRD   = 2'd0;
  localparam bus_cmd_t CMD_BUSRDX  = 2'd1;
  localparam bus_cmd_t CMD_BUSUPGR = 2'd2;
  localparam bus_cmd_t CMD_WB      = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMPARE = 3'd1;
  localparam logic [2:0] ST_UPGR    = 3'd2;
  localparam logic [2:0] ST_WB      = 3'd3;
  localparam logic [2:0] ST_FILL    = 3'd4;

  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped line storage (state/tag/data) with a CPU/fill port, a snoop
// read-modify port with registered responses, and a debug state read port.
module msi_line_array
  import msi_pkg::*;
#(
  parameter int INDEX_W = 1,
  parameter int TAG_W   = 2,
  parameter int DATA_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] cpu_index,
  output logic [1:0]         rd_state,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [1:0]         wr_state,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               snoop_valid,
  input  logic [1:0]         snoop_cmd,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag,
  output logic               snoop_hit,
  output logic               snoop_flush,
  output logic [DATA_W-1:0]  snoop_data,
  input  logic [INDEX_W-1:0] dbg_index,
  output logic [1:0]         dbg_state
);
  localparam int LINES = 1 << INDEX_W;

  line_state_t       state_q [LINES];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [DATA_W-1:0] data_q  [LINES];

  line_state_t sn_state, sn_next;
  logic        sn_match, sn_hit, sn_flush;

  assign rd_state  = state_q[cpu_index];
  assign rd_tag    = tag_q[cpu_index];
  assign rd_data   = data_q[cpu_index];
  assign dbg_state = state_q[dbg_index];

  always_comb begin
    sn_state = state_q[snoop_index];
    sn_match = snoop_valid && (sn_state != LINE_I) && (tag_q[snoop_index] == snoop_tag);
    sn_hit   = 1'b0;
    sn_flush = 1'b0;
    sn_next  = sn_state;
    if (sn_match) begin
      case (snoop_cmd)
        CMD_BUSRD: begin
          sn_hit   = 1'b1;
          sn_flush = (sn_state == LINE_M);
          sn_next  = LINE_S;
        end
        CMD_BUSRDX: begin
          sn_hit   = 1'b1;
          sn_flush = (sn_state == LINE_M);
          sn_next  = LINE_I;
        end
        CMD_BUSUPGR: begin
          if (sn_state == LINE_S) begin
            sn_hit  = 1'b1;
            sn_next = LINE_I;
          end
        end
        default: ;
      endcase
    end
  end

  // Snoop update is written first so a same-cycle local write to the line wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        state_q[i] <= LINE_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      snoop_hit   <= 1'b0;
      snoop_flush <= 1'b0;
      snoop_data  <= '0;
    end else begin
      snoop_hit   <= sn_hit;
      snoop_flush <= sn_flush;
      snoop_data  <= sn_flush ? data_q[snoop_index] : '0;
      if (sn_match) state_q[snoop_index] <= sn_next;
      if (wr_en) begin
        state_q[cpu_index] <= wr_state;
        tag_q[cpu_index]   <= wr_tag;
        data_q[cpu_index]  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back MSI cache controller: processor handshake, shared
// bus master port and snoop port in front of a common memory.
//
//   state   | meaning
//   IDLE    | waiting for cpu_req; request fields latched on accept
//   COMPARE | tag/state lookup, hits complete here
//   UPGR    | BusUpgr for a write hit on an S line
//   WB      | WriteBack of a modified victim
//   FILL    | BusRd / BusRdX fill, install and complete
module msi_cache_ctrl
  import msi_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4,
  parameter int INDEX_W = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_write,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               bus_req,
  output logic [1:0]         bus_cmd,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic               bus_ack,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               snoop_valid,
  input  logic [1:0]         snoop_cmd,
  input  logic [ADDR_W-1:0]  snoop_addr,
  output logic               snoop_hit,
  output logic               snoop_flush,
  output logic [DATA_W-1:0]  snoop_data,
  output logic [1:0]         dbg_state,
  input  logic [INDEX_W-1:0] dbg_index
);
  localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

  logic [2:0]         state_q, state_d;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;

  line_state_t        rd_state, wr_state;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic [DATA_W-1:0]  rd_data, wr_data;
  logic               wr_en, line_hit;

  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign line_hit  = (rd_state != LINE_I) && (rd_tag == req_tag);

  msi_line_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lines (
    .clock      (clock),
    .reset      (reset),
    .cpu_index  (req_index),
    .rd_state   (rd_state),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_state   (wr_state),
    .wr_tag     (wr_tag),
    .wr_data    (wr_data),
    .snoop_valid(snoop_valid),
    .snoop_cmd  (snoop_cmd),
    .snoop_index(snoop_addr[INDEX_W-1:0]),
    .snoop_tag  (snoop_addr[ADDR_W-1:INDEX_W]),
    .snoop_hit  (snoop_hit),
    .snoop_flush(snoop_flush),
    .snoop_data (snoop_data),
    .dbg_index  (dbg_index),
    .dbg_state  (dbg_state)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cpu_req) begin
        req_write <= cpu_write;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    bus_req   = 1'b0;
    bus_cmd   = CMD_BUSRD;
    bus_addr  = '0;
    bus_wdata = '0;
    wr_en     = 1'b0;
    wr_state  = rd_state;
    wr_tag    = rd_tag;
    wr_data   = rd_data;
    case (state_q)
      ST_IDLE: if (cpu_req) state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (line_hit && !req_write) begin
          cpu_ready = 1'b1;
          cpu_rdata = rd_data;
          state_d   = ST_IDLE;
        end else if (line_hit && rd_state == LINE_M) begin
          wr_en     = 1'b1;
          wr_data   = req_wdata;
          cpu_ready = 1'b1;
          state_d   = ST_IDLE;
        end else if (line_hit) begin
          state_d = ST_UPGR;
        end else if (rd_state == LINE_M) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_UPGR: begin
        // A snoop that invalidated our S copy turns the upgrade into a full
        // BusRdX; the request drops for this one cycle.
        if (rd_state == LINE_I) begin
          state_d = ST_FILL;
        end else begin
          bus_req  = 1'b1;
          bus_cmd  = CMD_BUSUPGR;
          bus_addr = req_addr;
          if (bus_ack) begin
            wr_en     = 1'b1;
            wr_state  = LINE_M;
            wr_data   = req_wdata;
            cpu_ready = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WB: begin
        bus_req   = 1'b1;
        bus_cmd   = CMD_WB;
        bus_addr  = {rd_tag, req_index};
        bus_wdata = rd_data;
        if (bus_ack) begin
          wr_en    = 1'b1;
          wr_state = LINE_I;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        bus_req  = 1'b1;
        bus_cmd  = req_write ? CMD_BUSRDX : CMD_BUSRD;
        bus_addr = req_addr;
        if (bus_ack) begin
          wr_en     = 1'b1;
          wr_tag    = req_tag;
          wr_state  = req_write ? LINE_M : LINE_S;
          wr_data   = req_write ? req_wdata : bus_rdata;
          cpu_ready = 1'b1;
          cpu_rdata = req_write ? '0 : bus_rdata;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
Parametrised direct-mapped write-back cache controller using the MSI snooping protocol. It is the next generation of the single-line processor/directory cache pair, generalised to 2^INDEX_W lines and arbitrary address and data widths. It adds a processor request/ready handshake, a shared-bus master port (BusRd, BusRdX, BusUpgr, WriteBack) and a snoop port. Several instances sit on a common bus in front of the shared memory block.

Parameters:
ADDR_W, 3, processor/bus address width (bits).
DATA_W, 4, word width; one word per line.
INDEX_W, 1, index bits; lines = 2^INDEX_W; tag width TAG_W = ADDR_W-INDEX_W (must be >=1).

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  request valid; sampled only in IDLE.
cpu_write  in  1  1=write, 0=read.
cpu_addr  in  ADDR_W  request address.
cpu_wdata  in  DATA_W  write data.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data, valid with cpu_ready.
bus_req  out  1  bus transaction request; held until bus_ack.
bus_cmd  out  2  0=BusRd, 1=BusRdX, 2=BusUpgr, 3=WriteBack.
bus_addr  out  ADDR_W  transaction address.
bus_wdata  out  DATA_W  WriteBack data.
bus_ack  in  1  one-cycle completion; bus_rdata valid for BusRd/BusRdX.
bus_rdata  in  DATA_W  fill data.
snoop_valid  in  1  one-cycle snooped transaction from another cache.
snoop_cmd  in  2  encoding as bus_cmd.
snoop_addr  in  ADDR_W  snooped address.
snoop_hit  out  1  registered; matching line was valid.
snoop_flush  out  1  registered; matching line was M, data driven.
snoop_data  out  DATA_W  flushed data, valid with snoop_flush.
dbg_state  out  2  MSI state of line dbg_index, for HEX display.
dbg_index  in  INDEX_W  debug line select (combinational read).

Behaviour:
- Line state encoding: I=0, S=1, M=2. Each line holds state, tag, data.
- Reset: every line I, tag 0, data 0. FSM to IDLE. All outputs 0. A transaction in flight is abandoned; bus_req is low the cycle after reset is sampled.
- FSM states: IDLE, COMPARE, UPGR, WB, FILL.
- IDLE: on cpu_req, latch write/addr/wdata and go to COMPARE.
- COMPARE, read hit (S or M): cpu_ready=1, cpu_rdata=line data, return to IDLE. Latency is 2 cycles from the cpu_req edge.
- COMPARE, write hit M: write data, cpu_ready=1, go to IDLE.
- COMPARE, write hit S: go to UPGR.
- COMPARE, miss with victim M: go to WB.
- COMPARE, any other miss: go to FILL.
- UPGR: bus_req=1, bus_cmd=BusUpgr. On bus_ack: line->M, write data, cpu_ready, go to IDLE. If a snoop invalidates the line before bus_ack: drop bus_req for one cycle, then go to FILL as BusRdX.
- WB: bus_cmd=WriteBack, bus_addr={victim tag,index}, bus_wdata=victim data. On bus_ack: victim->I, go to FILL.
- FILL: bus_cmd=BusRd for reads, BusRdX for writes. On bus_ack install tag and data:
  - read -> S, cpu_rdata=bus_rdata.
  - write -> M, data=cpu_wdata.
  - cpu_ready pulses in the same cycle as the install.
- bus_addr, bus_cmd and bus_wdata are stable while bus_req=1.
- Snoop is processed every cycle in every FSM state, on a valid line with matching tag:
  - BusRd: S -> S, hit; M -> S, hit, flush.
  - BusRdX: S -> I, hit; M -> I, hit, flush.
  - BusUpgr: S -> I, hit.
  - WriteBack: ignored.
  - snoop_hit, snoop_flush and snoop_data are registered and appear 1 cycle after snoop_valid; otherwise they are 0.
- Simultaneous events, same line and same edge: the snoop transition applies first, then the local update, so a fill install wins. Snoops never block the FSM.
- Snoop of a victim in WB state: flush, line->I, and the WB completes normally (memory tolerates a duplicate write).

Decomposition:
- Package msi_pkg: line-state constants (I/S/M), bus_cmd constants, FSM state encoding, and TAG_W derivation helper.
- Sub-module msi_line_array: tag/state/data storage with one CPU/fill write port, one snoop read-modify port and the debug read port.
- The FSM and bus logic stay in msi_cache_ctrl.

Test Plan:
1. Reset, then read addr 3'b101 -> BusRd issued, bus_ack with rdata 4'hA -> cpu_ready, rdata=A; line1 state S (dbg_state=1); repeat read -> hit in 2 cycles, no bus_req.
2. After scenario 1, write 4'h7 to addr 5 -> BusUpgr, ack -> state M; snoop BusRd addr 5 -> next cycle snoop_hit=1, snoop_flush=1, snoop_data=7; state S.
3. Line0 M with tag 2'b01, data 4'h3; read addr 3'b100 -> WriteBack addr 3'b010 data 3, then BusRd addr 4, ack rdata 4'hC -> rdata C, state S.
4. In UPGR for addr 5, snoop BusUpgr addr 5 before bus_ack -> bus_req low one cycle, then BusRdX; ack rdata 4'h1 -> line M with data = cpu_wdata.
5. Snoop BusRdX to a tag-mismatched or I line -> snoop_hit=0, no state change.
6. Assert reset during FILL -> next cycle bus_req=0 and all lines I; a subsequent read to the same address reissues BusRd.
